// File: rtl/onehot_to_bin_pipe.sv
// ============================================================================
// onehot_to_bin_pipe : two-stage valid/ready one-hot to binary encoder with
//                      multi-hot resolution, zero/multi flags, error counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module onehot_to_bin_pipe #(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
  parameter int MODE         = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ONEHOT_WIDTH-1:0] in_onehot,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_WIDTH-1:0]    out_bin,
  output logic                    out_zero,
  output logic                    out_multi,
  input  logic                    err_clr,
  output logic [CNT_WIDTH-1:0]    err_cnt
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                    a_valid_q, a_valid_d;
  logic [ONEHOT_WIDTH-1:0] a_vec_q, a_vec_d;
  logic                    out_valid_q, out_valid_d;
  logic [BIN_WIDTH-1:0]    out_bin_q, out_bin_d;
  logic                    out_zero_q, out_zero_d;
  logic                    out_multi_q, out_multi_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;

  logic                    w_accept;
  logic                    w_b_load;
  logic                    w_deliver;
  logic [BIN_WIDTH-1:0]    w_enc_or, w_enc_lo, w_enc_hi, w_enc_sel;
  logic                    w_lo_found;
  logic                    w_zero, w_multi;

  // Ready never looks at in_valid, so there is no valid->ready loop.
  assign in_ready  = !a_valid_q || !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_b_load  = a_valid_q && (!out_valid_q || out_ready);
  assign w_deliver = out_valid_q && out_ready;

  always_comb begin
    w_enc_or   = '0;
    w_enc_lo   = '0;
    w_enc_hi   = '0;
    w_lo_found = 1'b0;
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (a_vec_q[i]) begin
        w_enc_or = w_enc_or | BIN_WIDTH'(i);
        w_enc_hi = BIN_WIDTH'(i);
        if (!w_lo_found) begin
          w_enc_lo   = BIN_WIDTH'(i);
          w_lo_found = 1'b1;
        end
      end
    end
    w_zero  = ~|a_vec_q;
    // Clearing the lowest set bit leaves something only when two or more were set.
    w_multi = |(a_vec_q & (a_vec_q - ONEHOT_WIDTH'(1)));
    if (MODE == 1)      w_enc_sel = w_enc_lo;
    else if (MODE == 2) w_enc_sel = w_enc_hi;
    else                w_enc_sel = w_enc_or;
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_vec_d     = a_vec_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;
    err_cnt_d   = err_cnt_q;

    if (w_accept) begin
      a_valid_d = 1'b1;
      a_vec_d   = in_onehot;
    end else if (w_b_load) begin
      a_valid_d = 1'b0;
    end

    if (w_b_load) begin
      out_valid_d = 1'b1;
      out_bin_d   = w_enc_sel;
      out_zero_d  = w_zero;
      out_multi_d = w_multi;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (w_deliver && (out_zero_q || out_multi_q) && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_vec_q     <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_vec_q     <= a_vec_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: doc/onehot_to_bin_pipe.md
# onehot_to_bin_pipe

Pipelined, flow-controlled one-hot to binary encoder. It generalises the combinational encoder with:
- selectable multi-hot resolution mode (OR-merge, lowest-index, or highest-index);
- zero-hot and multi-hot detection flags;
- a saturating error counter;
- a two-stage valid/ready pipeline that sustains one beat per clock under backpressure.

It sits between arbiters or grant vectors and index-consuming logic (queue selects, table lookups) where timing closure needs registered boundaries.

## Interface
- ONEHOT_WIDTH, 16, input vector width; legal range is 2 or more.
- BIN_WIDTH, $clog2(ONEHOT_WIDTH), output index width.
- MODE, 0, multi-hot resolution:
  - 0 = OR of all set indices (legacy encoder behaviour);
  - 1 = lowest set index wins;
  - 2 = highest set index wins.
- CNT_WIDTH, 8, error counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_onehot  input  ONEHOT_WIDTH  vector to encode.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_bin  output  BIN_WIDTH  encoded index.
- out_zero  output  1  beat had no bits set.
- out_multi  output  1  beat had two or more bits set.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_WIDTH  saturating count of delivered beats with out_zero or out_multi.

## Operation
- Stage A register (a_valid, a_vec) captures in_onehot on accept.
- Combinational encode runs from a_vec into stage B register (out_valid, out_bin, out_zero, out_multi).
- Encode rules:
  - zero-hot: out_bin = 0, out_zero = 1, out_multi = 0.
  - one-hot: out_bin = index of the set bit, both flags 0.
  - multi-hot: out_multi = 1, out_bin per MODE.
- MODE 0 multi-hot example: bits 3 and 5 give 3|5 = 7.
- Bit indices at or above 2^BIN_WIDTH cannot occur, since BIN_WIDTH ≥ $clog2(ONEHOT_WIDTH).
- Flags are independent of MODE.
- Stage B advance condition: b_load = a_valid && (!out_valid || out_ready).
- Stage A accept condition: in_ready = !a_valid || !out_valid || out_ready. This is combinational from out_ready and state; there is no combinational path from in_valid to in_ready.
- On b_load, a_valid clears unless a new beat is accepted in the same cycle.
- Stage B drop condition: out_valid clears on out_ready when there is no b_load.
- Data ordering is strictly FIFO. No beat is dropped or duplicated.
- Error counter:
  - On each delivered beat (out_valid && out_ready) with out_zero || out_multi, err_cnt increments by 1.
  - It saturates at 2^CNT_WIDTH − 1; there is no wrap.
  - err_clr has priority: err_clr together with an increment yields 0.
- Reset (rst_n = 0 at an edge):
  - a_valid = 0, out_valid = 0, out_bin = 0, out_zero = 0, out_multi = 0, err_cnt = 0.
  - in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards both stages with no output. Beats in flight are lost by design.

## Timing
- Latency: a beat accepted at edge k is presented on out_* from edge k+1. It is visible in the cycle after acceptance plus one register stage, i.e. 2 cycles from input presentation to output.
- Throughput: 1 beat per clock while out_ready = 1.
- Capacity: 2 beats (A + B).
- With out_ready held 0:
  - the block accepts exactly 2 beats;
  - in_ready = 0 on the cycle after the second accept;
  - out_* hold stable while out_valid && !out_ready.
- When out_ready rises with both stages full:
  - B delivers;
  - A moves to B;
  - a new beat is accepted into A in the same cycle.
- err_cnt updates on the edge of delivery. Its value is visible the following cycle.

## Test plan
- Reset then one-hot sweep, MODE 0, ONEHOT_WIDTH 16: drive in_onehot = 1<<i for i = 0..15 back-to-back with out_ready = 1.
  - out_bin = 0..15 in order, starting 2 cycles after first presentation, one per cycle.
  - Flags 0, err_cnt = 0.
- Multi-hot per mode: drive 16'h0028 (bits 3 and 5).
  - MODE 0: out_bin = 7.
  - MODE 1: out_bin = 3.
  - MODE 2: out_bin = 5.
  - out_multi = 1 in all modes; err_cnt = 1 after delivery.
- Zero input: drive 16'h0000.
  - out_bin = 0, out_zero = 1, out_multi = 0; err_cnt increments.
- Backpressure: hold out_ready = 0 and offer 4 beats.
  - Exactly 2 are accepted, then in_ready = 0 and out_* stay stable.
  - Release out_ready: all 4 beats are delivered in order, with no gaps after release.
- Counter saturation and clear, CNT_WIDTH 2: deliver 5 zero-hot beats.
  - err_cnt reads 1, 2, 3, 3, 3.
  - Assert err_clr on the cycle of a 6th error delivery: err_cnt = 0.
- Reset mid-stream: with both stages full, assert rst_n = 0 for 1 cycle.
  - out_valid = 0, err_cnt = 0, in_ready = 1 next cycle.
  - No stale beat appears afterwards.
